// File: rtl/bf2_pair_buffer.sv
// Input stage for a radix-2 DIF butterfly: buffers the first half of each frame
// and emits (x[k], x[k+N/2], k) pairs through a registered valid/ready output.
module bf2_pair_buffer #(
  parameter int DataWidth = 16,
  parameter int LogN      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic signed [DataWidth-1:0] In_Re,
  input  logic signed [DataWidth-1:0] In_Im,
  output logic                        Start,
  input  logic                        Pair_Ready,
  output logic signed [DataWidth-1:0] X0_Re,
  output logic signed [DataWidth-1:0] X0_Im,
  output logic signed [DataWidth-1:0] X1_Re,
  output logic signed [DataWidth-1:0] X1_Im,
  output logic [LogN-2:0]             Tw_Index,
  output logic                        Pair_Last
);

  localparam int Half = 1 << (LogN - 1);
  localparam int CntW = LogN - 1;

  typedef enum logic {
    FILL,
    PAIR
  } state_e;

  typedef struct packed {
    logic signed [DataWidth-1:0] re;
    logic signed [DataWidth-1:0] im;
  } sample_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_en_q;
  logic            start_q, start_d;
  logic            last_q, last_d;
  logic [CntW-1:0] tw_q, tw_d;
  sample_t         x0_q, x0_d;
  sample_t         x1_q, x1_d;
  sample_t         mem_q [Half];
  sample_t         in_sample;
  sample_t         rd_sample;
  logic            accept;
  logic            handoff;
  logic            cnt_last;
  logic            mem_we;

  assign in_sample = {In_Re, In_Im};
  assign rd_sample = mem_q[cnt_q];
  assign cnt_last  = (cnt_q == CntW'(Half - 1));

  // In PAIR the output register must be empty or draining before a new pair can land.
  assign In_Ready = ready_en_q & ((state_q == FILL) | ~start_q | Pair_Ready);
  assign accept   = In_Valid & In_Ready;
  assign handoff  = start_q & Pair_Ready;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    last_d  = last_q;
    tw_d    = tw_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    mem_we  = 1'b0;

    if (handoff) begin
      start_d = 1'b0;
    end

    if (accept) begin
      // The counter width equals log2(N/2), so it wraps to 0 on the last sample of each half.
      cnt_d = cnt_q + CntW'(1);
      if (state_q == FILL) begin
        mem_we = 1'b1;
        if (cnt_last) begin
          state_d = PAIR;
        end
      end else begin
        x0_d    = rd_sample;
        x1_d    = in_sample;
        tw_d    = cnt_q;
        last_d  = cnt_last;
        start_d = 1'b1;
        if (cnt_last) begin
          state_d = FILL;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
      start_q    <= 1'b0;
      last_q     <= 1'b0;
      tw_q       <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      start_q    <= start_d;
      last_q     <= last_d;
      tw_q       <= tw_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
    end
  end

  // NOTE: the sample store has no reset; every entry is written in FILL before
  // PAIR can read it, so reset would only cost flops.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cnt_q] <= in_sample;
    end
  end

  assign Start     = start_q;
  assign Pair_Last = last_q;
  assign Tw_Index  = tw_q;
  assign X0_Re     = x0_q.re;
  assign X0_Im     = x0_q.im;
  assign X1_Re     = x1_q.re;
  assign X1_Im     = x1_q.im;

endmodule

// File: tb/tb_bf2_pair_buffer.sv
// Self-checking bench for bf2_pair_buffer: frame-position reference model plus
// per-scenario directed/randomized checks.
module tb_bf2_pair_buffer;

  localparam int DW   = 16;
  localparam int LOGN = 4;
  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 In_Valid = 1'b0;
  logic                 In_Ready;
  logic signed [DW-1:0] In_Re = '0;
  logic signed [DW-1:0] In_Im = '0;
  logic                 Start;
  logic                 Pair_Ready;
  logic signed [DW-1:0] X0_Re, X0_Im, X1_Re, X1_Im;
  logic [LOGN-2:0]      Tw_Index;
  logic                 Pair_Last;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic signed [DW-1:0] x0r;
    logic signed [DW-1:0] x0i;
    logic signed [DW-1:0] x1r;
    logic signed [DW-1:0] x1i;
    logic [LOGN-2:0]      tw;
    logic                 last;
    int                   cyc;
  } pair_t;

  pair_t got_q[$];

  bf2_pair_buffer #(.DataWidth(DW), .LogN(LOGN)) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Re     (In_Re),
    .In_Im     (In_Im),
    .Start     (Start),
    .Pair_Ready(Pair_Ready),
    .X0_Re     (X0_Re),
    .X0_Im     (X0_Im),
    .X1_Re     (X1_Re),
    .X1_Im     (X1_Im),
    .Tw_Index  (Tw_Index),
    .Pair_Last (Pair_Last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern: 0 = always, 1 = alternate, 2 = never, 3 = random.
  int pr_mode = 0;
  bit pr_tog  = 1'b0;
  always @(posedge clk) begin
    #1;
    case (pr_mode)
      0:       Pair_Ready = 1'b1;
      1:       begin pr_tog = ~pr_tog; Pair_Ready = pr_tog; end
      2:       Pair_Ready = 1'b0;
      default: Pair_Ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: position within the frame, stored first half, one pending pair.
  bit                   sb_en = 1'b0;
  int                   m_pos;
  logic signed [DW-1:0] m_fr [HALF];
  logic signed [DW-1:0] m_fi [HALF];
  bit                   m_pend;
  pair_t                m_out;

  always @(negedge clk) begin
    bit    exp_ready;
    pair_t obs;
    if (!sb_en) begin
      m_pos  = 0;
      m_pend = 1'b0;
    end else begin
      exp_ready = (m_pos < HALF) || !m_pend || (Pair_Ready === 1'b1);
      n_checks++;
      if (In_Ready !== exp_ready) begin
        n_fail++;
        $display("FAIL sb_in_ready cyc=%0d got=%b exp=%b", cyc, In_Ready, exp_ready);
      end
      n_checks++;
      if (Start !== m_pend) begin
        n_fail++;
        $display("FAIL sb_start cyc=%0d got=%b exp=%b", cyc, Start, m_pend);
      end
      obs = '{X0_Re, X0_Im, X1_Re, X1_Im, Tw_Index, Pair_Last, cyc};
      if (m_pend) begin
        n_checks++;
        if (obs.x0r !== m_out.x0r || obs.x0i !== m_out.x0i || obs.x1r !== m_out.x1r ||
            obs.x1i !== m_out.x1i || obs.tw !== m_out.tw || obs.last !== m_out.last) begin
          n_fail++;
          $display("FAIL sb_pair cyc=%0d got (%0d,%0d)(%0d,%0d) tw=%0d last=%b exp (%0d,%0d)(%0d,%0d) tw=%0d last=%b",
                   cyc, obs.x0r, obs.x0i, obs.x1r, obs.x1i, obs.tw, obs.last,
                   m_out.x0r, m_out.x0i, m_out.x1r, m_out.x1i, m_out.tw, m_out.last);
        end
        if (Pair_Ready === 1'b1) begin
          got_q.push_back(obs);
          m_pend = 1'b0;
        end
      end
      if (In_Valid && exp_ready) begin
        if (m_pos < HALF) begin
          m_fr[m_pos] = In_Re;
          m_fi[m_pos] = In_Im;
        end else begin
          m_out.x0r  = m_fr[m_pos - HALF];
          m_out.x0i  = m_fi[m_pos - HALF];
          m_out.x1r  = In_Re;
          m_out.x1i  = In_Im;
          m_out.tw   = (LOGN-1)'(m_pos - HALF);
          m_out.last = (m_pos == N - 1);
          m_pend     = 1'b1;
        end
        m_pos = (m_pos + 1) % N;
      end
    end
  end

  // Tasks start and end at posedge+1 so inputs change away from the sampling edge.
  task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                      output int acc_cyc, output int waits);
    waits    = 0;
    acc_cyc  = -1;
    In_Valid = 1'b1;
    In_Re    = re;
    In_Im    = im;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (In_Ready === 1'b1) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        In_Valid = 1'b0;
        return;
      end
      waits++;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout re=%0d got=no_accept exp=accept_within_64", re);
    In_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    In_Valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic assert_reset();
    sb_en    = 1'b0;
    In_Valid = 1'b0;
    #2 reset = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (In_Ready !== 1'b0 || Start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held got ready=%b start=%b exp 0 0", In_Ready, Start);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (In_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_preclk got ready=%b exp 0", In_Ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (In_Ready !== 1'b1 || Start !== 1'b0 || Pair_Last !== 1'b0 || Tw_Index !== '0 ||
        X0_Re !== '0 || X0_Im !== '0 || X1_Re !== '0 || X1_Im !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got ready=%b start=%b last=%b tw=%0d x0=%0d,%0d x1=%0d,%0d exp ready=1 rest 0",
               In_Ready, Start, Pair_Last, Tw_Index, X0_Re, X0_Im, X1_Re, X1_Im);
    end
    sb_en = 1'b1;
  endtask

  task automatic test_continuous();
    int base, c0, ac, w;
    pr_mode = 0;
    base = got_q.size();
    c0 = -1;
    for (int n = 0; n < N; n++) begin
      send(16'(n), 16'(-n), ac, w);
      if (n == 0) c0 = ac;
    end
    idle(3);
    n_checks++;
    if (got_q.size() - base != HALF) begin
      n_fail++;
      $display("FAIL cont_count got=%0d exp=%0d", got_q.size() - base, HALF);
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pair_t p = got_q[base + k];
        n_checks++;
        if (p.x0r !== 16'(k) || p.x1r !== 16'(k + HALF) || p.x0i !== 16'(-k) ||
            p.x1i !== 16'(-(k + HALF)) || p.tw !== 3'(k) || p.last !== (k == HALF - 1) ||
            p.cyc != c0 + HALF + 1 + k) begin
          n_fail++;
          $display("FAIL cont_pair k=%0d got x0=%0d x1=%0d tw=%0d last=%b cyc=%0d exp x0=%0d x1=%0d cyc=%0d",
                   k, p.x0r, p.x1r, p.tw, p.last, p.cyc, k, k + HALF, c0 + HALF + 1 + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base, ac, w;
    pr_mode = 2;
    base = got_q.size();
    for (int n = 0; n <= HALF; n++) send(16'(100 + n), 16'(-100 - n), ac, w);
    In_Valid = 1'b1;
    In_Re    = 16'(100 + HALF + 1);
    In_Im    = 16'(-100 - HALF - 1);
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (In_Ready !== 1'b0 || Start !== 1'b1 || X0_Re !== 16'sd100 || X1_Re !== 16'(100 + HALF)) begin
        n_fail++;
        $display("FAIL bp_hold got ready=%b start=%b x0=%0d x1=%0d exp ready=0 start=1 x0=100 x1=%0d",
                 In_Ready, Start, X0_Re, X1_Re, 100 + HALF);
      end
      @(posedge clk); #1;
    end
    pr_mode = 1;
    for (int n = HALF + 1; n < N; n++) send(16'(100 + n), 16'(-100 - n), ac, w);
    pr_mode = 0;
    idle(4);
    n_checks++;
    if (got_q.size() - base != HALF) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=%0d", got_q.size() - base, HALF);
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pair_t p = got_q[base + k];
        n_checks++;
        if (p.x0r !== 16'(100 + k) || p.x1r !== 16'(100 + HALF + k) || p.tw !== 3'(k)) begin
          n_fail++;
          $display("FAIL bp_order k=%0d got x0=%0d x1=%0d tw=%0d exp x0=%0d x1=%0d tw=%0d",
                   k, p.x0r, p.x1r, p.tw, 100 + k, 100 + HALF + k, k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, c0, ac, w, waits;
    pr_mode = 0;
    base  = got_q.size();
    waits = 0;
    c0    = -1;
    for (int n = 0; n < 2 * N; n++) begin
      send(16'(n), 16'(~n), ac, w);
      waits += w;
      if (n == 0) c0 = ac;
    end
    idle(3);
    n_checks++;
    if (waits != 0) begin
      n_fail++;
      $display("FAIL b2b_stalls got=%0d exp=0", waits);
    end
    n_checks++;
    if (got_q.size() - base != 2 * HALF) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - base, 2 * HALF);
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pair_t p = got_q[base + HALF + k];
        n_checks++;
        if (p.x0r !== 16'(N + k) || p.x1r !== 16'(N + HALF + k) || p.x0i !== 16'(~(N + k)) ||
            p.x1i !== 16'(~(N + HALF + k)) || p.tw !== 3'(k) || p.last !== (k == HALF - 1) ||
            p.cyc != c0 + N + HALF + 1 + k) begin
          n_fail++;
          $display("FAIL b2b_pair k=%0d got x0=%0d x1=%0d tw=%0d last=%b cyc=%0d exp x0=%0d x1=%0d cyc=%0d",
                   k, p.x0r, p.x1r, p.tw, p.last, p.cyc, N + k, N + HALF + k, c0 + N + HALF + 1 + k);
        end
      end
    end
  endtask

  task automatic test_extreme();
    logic signed [DW-1:0] vr [N];
    logic signed [DW-1:0] vi [N];
    int base, ac, w;
    for (int n = 0; n < N; n++) begin
      case ($urandom_range(0, 2))
        0:       vr[n] = 16'h8000;
        1:       vr[n] = 16'h7FFF;
        default: vr[n] = 16'($urandom);
      endcase
      vi[n] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
    end
    vr[0] = 16'h8000;
    vi[HALF] = 16'h7FFF;
    pr_mode = 3;
    base = got_q.size();
    for (int n = 0; n < N; n++) send(vr[n], vi[n], ac, w);
    pr_mode = 0;
    idle(4);
    n_checks++;
    if (got_q.size() - base != HALF) begin
      n_fail++;
      $display("FAIL ext_count got=%0d exp=%0d", got_q.size() - base, HALF);
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pair_t p = got_q[base + k];
        n_checks++;
        if (p.x0r !== vr[k] || p.x0i !== vi[k] || p.x1r !== vr[k + HALF] || p.x1i !== vi[k + HALF]) begin
          n_fail++;
          $display("FAIL ext_pair k=%0d got %h,%h %h,%h exp %h,%h %h,%h", k, p.x0r, p.x0i,
                   p.x1r, p.x1i, vr[k], vi[k], vr[k + HALF], vi[k + HALF]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int base, ac, w;
    pr_mode = 0;
    for (int n = 0; n < 5; n++) send(16'(16'h1000 + n), 16'(16'h1100 + n), ac, w);
    assert_reset();
    n_checks++;
    if (Start !== 1'b0 || In_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mreset_fill got start=%b ready=%b exp 0 0", Start, In_Ready);
    end
    release_reset();
    pr_mode = 2;
    for (int n = 0; n <= HALF; n++) send(16'(16'h2000 + n), 16'(16'h2100 + n), ac, w);
    @(posedge clk); #1;
    assert_reset();
    n_checks++;
    if (Start !== 1'b0 || In_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mreset_pending got start=%b ready=%b exp 0 0", Start, In_Ready);
    end
    release_reset();
    pr_mode = 0;
    base = got_q.size();
    for (int n = 0; n < N; n++) send(16'(16'h3000 + n), 16'(-(16'h3000 + n)), ac, w);
    idle(4);
    n_checks++;
    if (got_q.size() - base != HALF) begin
      n_fail++;
      $display("FAIL mreset_count got=%0d exp=%0d", got_q.size() - base, HALF);
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pair_t p = got_q[base + k];
        n_checks++;
        if (p.x0r !== 16'(16'h3000 + k) || p.x1r !== 16'(16'h3000 + HALF + k) ||
            p.x0i !== 16'(-(16'h3000 + k)) || p.tw !== 3'(k)) begin
          n_fail++;
          $display("FAIL mreset_pair k=%0d got x0=%h x1=%h tw=%0d exp x0=%h x1=%h tw=%0d",
                   k, p.x0r, p.x1r, p.tw, 16'h3000 + k, 16'h3000 + HALF + k, k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_back_to_back();
    test_extreme();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
